// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory stage: load/store over a req/ack data port, lane alignment and load extension
module mem_access_stage #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALU_result,
    input  logic [31:0] Read_data_2,
    input  logic        Controller_memread,
    input  logic        Controller_memwrite,
    input  logic [1:0]  Controller_memsize,
    input  logic        Controller_memsigned,
    input  logic        ALU_kick_up,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] MEM_result,
    output logic        MEM_misaligned,
    output logic        MEM_fault,
    output logic        MEM_busy,
    output logic        MEM_kick_up
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(ACK_TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [1:0]  size_q, size_n;
    logic        signed_q, signed_n;
    logic [1:0]  lane_q, lane_n;

    logic        req_n, we_n;
    logic [31:0] addr_n, wdata_n;
    logic [3:0]  be_n;
    logic [31:0] result_n;
    logic        misaligned_n, fault_n, busy_n, kick_n;

    logic        mem_op;
    logic        addr_misaligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;

    assign mem_op = Controller_memread | Controller_memwrite;

    always_comb begin
        addr_misaligned = 1'b0;
        case (Controller_memsize)
            2'b00:   addr_misaligned = 1'b0;
            2'b01:   addr_misaligned = ALU_result[0];
            default: addr_misaligned = |ALU_result[1:0];
        endcase
    end

    // Little-endian lane pick from the latched low address bits.
    always_comb begin
        byte_sel = dmem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_val = signed_q ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
            2'b01:   load_val = signed_q ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        size_n       = size_q;
        signed_n     = signed_q;
        lane_n       = lane_q;
        req_n        = dmem_req;
        we_n         = dmem_we;
        addr_n       = dmem_addr;
        wdata_n      = dmem_wdata;
        be_n         = dmem_be;
        result_n     = MEM_result;
        misaligned_n = MEM_misaligned;
        fault_n      = MEM_fault;
        busy_n       = MEM_busy;
        kick_n       = 1'b0;

        case (state)
            IDLE: begin
                if (ALU_kick_up) begin
                    misaligned_n = 1'b0;
                    fault_n      = 1'b0;
                    if (!mem_op) begin
                        result_n = ALU_result;
                        kick_n   = 1'b1;
                    end else if (addr_misaligned) begin
                        result_n     = 32'b0;
                        misaligned_n = 1'b1;
                        kick_n       = 1'b1;
                    end else begin
                        size_n   = Controller_memsize;
                        signed_n = Controller_memsigned;
                        lane_n   = ALU_result[1:0];
                        req_n    = 1'b1;
                        we_n     = Controller_memwrite;
                        addr_n   = {ALU_result[31:2], 2'b00};
                        busy_n   = 1'b1;
                        cnt_n    = 8'd0;
                        state_n  = ACCESS;
                        wdata_n  = 32'b0;
                        be_n     = 4'b0000;
                        if (Controller_memwrite) begin
                            case (Controller_memsize)
                                2'b00: begin
                                    wdata_n = {4{Read_data_2[7:0]}};
                                    be_n    = 4'b0001 << ALU_result[1:0];
                                end
                                2'b01: begin
                                    wdata_n = {2{Read_data_2[15:0]}};
                                    be_n    = 4'b0011 << {ALU_result[1], 1'b0};
                                end
                                default: begin
                                    wdata_n = Read_data_2;
                                    be_n    = 4'b1111;
                                end
                            endcase
                        end
                    end
                end
            end

            ACCESS: begin
                if (dmem_ack) begin
                    req_n    = 1'b0;
                    result_n = dmem_we ? 32'b0 : load_val;
                    state_n  = RESP;
                end else if (cnt == LAST_CNT) begin
                    req_n    = 1'b0;
                    fault_n  = 1'b1;
                    result_n = 32'b0;
                    state_n  = RESP;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end

            RESP: begin
                kick_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end

            default: begin
                req_n   = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            size_q         <= 2'b00;
            signed_q       <= 1'b0;
            lane_q         <= 2'b00;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= 32'b0;
            dmem_wdata     <= 32'b0;
            dmem_be        <= 4'b0000;
            MEM_result     <= 32'b0;
            MEM_misaligned <= 1'b0;
            MEM_fault      <= 1'b0;
            MEM_busy       <= 1'b0;
            MEM_kick_up    <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            size_q         <= size_n;
            signed_q       <= signed_n;
            lane_q         <= lane_n;
            dmem_req       <= req_n;
            dmem_we        <= we_n;
            dmem_addr      <= addr_n;
            dmem_wdata     <= wdata_n;
            dmem_be        <= be_n;
            MEM_result     <= result_n;
            MEM_misaligned <= misaligned_n;
            MEM_fault      <= fault_n;
            MEM_busy       <= busy_n;
            MEM_kick_up    <= kick_n;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized transaction-level check of mem_access_stage
module tb_mem_access_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ALU_result = '0;
    logic [31:0] Read_data_2 = '0;
    logic        Controller_memread = 1'b0;
    logic        Controller_memwrite = 1'b0;
    logic [1:0]  Controller_memsize = 2'b00;
    logic        Controller_memsigned = 1'b0;
    logic        ALU_kick_up = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] MEM_result;
    logic        MEM_misaligned;
    logic        MEM_fault;
    logic        MEM_busy;
    logic        MEM_kick_up;

    int total = 0;
    int bad = 0;

    mem_access_stage #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .ALU_result(ALU_result), .Read_data_2(Read_data_2),
        .Controller_memread(Controller_memread), .Controller_memwrite(Controller_memwrite),
        .Controller_memsize(Controller_memsize), .Controller_memsigned(Controller_memsigned),
        .ALU_kick_up(ALU_kick_up),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .MEM_result(MEM_result), .MEM_misaligned(MEM_misaligned), .MEM_fault(MEM_fault),
        .MEM_busy(MEM_busy), .MEM_kick_up(MEM_kick_up)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One complete operation; delay = ACCESS cycles before ack (>= T means never acked in time).
    task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdat,
                         input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                         input int delay);
        int nb, off, bits, exp_lat, exp_reqc, reqc, lat, kicks;
        logic mem, mis, tout, done;
        logic [31:0] exp_res, exp_be, exp_wd, mask, v;

        mem  = rd | wr;
        nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        off  = int'(a[1:0]);
        mis  = mem && ((off % nb) != 0);
        tout = mem && !mis && (delay >= T);
        exp_reqc = (!mem || mis) ? 0 : (tout ? T : delay + 1);
        exp_lat  = (!mem || mis) ? 1 : exp_reqc + 2;
        bits = nb * 8;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 32'h1);
        v    = (rdat >> (8 * off)) & mask;
        if (sg && nb < 4 && v[bits-1]) v = v | ~mask;
        exp_res = !mem ? a : ((mis || wr || tout) ? 32'h0 : v);
        exp_be  = wr ? (((32'h1 << nb) - 32'h1) << off) : 32'h0;
        exp_wd  = (nb == 1) ? d[7:0] * 32'h0101_0101 : (nb == 2) ? d[15:0] * 32'h0001_0001 : d;

        @(negedge clk);
        ALU_result = a; Read_data_2 = d; Controller_memread = rd; Controller_memwrite = wr;
        Controller_memsize = sz; Controller_memsigned = sg; dmem_rdata = rdat;
        ALU_kick_up = 1'b1;
        dmem_ack = 1'($urandom_range(0, 1));
        reqc = 0; lat = 0; kicks = 0; done = 1'b0;
        for (int i = 1; i <= 40 && !done; i++) begin
            @(negedge clk);
            ALU_kick_up = 1'b0;
            dmem_ack = 1'b0;
            if (dmem_req) begin
                if (reqc == 0) begin
                    check("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
                    check("dmem_we", 32'(dmem_we), 32'(wr));
                    check("dmem_be", 32'(dmem_be), exp_be);
                    if (wr) check("dmem_wdata", dmem_wdata, exp_wd);
                end
                reqc++;
                if (reqc - 1 == delay) dmem_ack = 1'b1;
            end
            if (MEM_kick_up) begin
                kicks++;
                lat = i;
                done = 1'b1;
                check("result", MEM_result, exp_res);
                check("misaligned", 32'(MEM_misaligned), 32'(mis));
                check("fault", 32'(MEM_fault), 32'(tout));
                check("busy_at_kick", 32'(MEM_busy), 32'h0);
            end else if (MEM_busy && $urandom_range(0, 3) == 0) begin
                ALU_kick_up = 1'b1;
                ALU_result = $urandom;
                Controller_memread = 1'($urandom);
                Controller_memwrite = 1'($urandom);
                Controller_memsize = 2'($urandom);
            end
        end
        if (!done) check("kick_up_timeout", 32'h0, 32'h1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("req_cycles", 32'(reqc), 32'(exp_reqc));
        @(negedge clk);
        check("kick_one_cycle", 32'(MEM_kick_up), 32'h0);
        check("req_idle", 32'(dmem_req), 32'h0);
    endtask

    initial begin
        #1;
        check("rst_req", 32'(dmem_req), 32'h0);
        check("rst_result", MEM_result, 32'h0);
        check("rst_flags", {28'h0, MEM_misaligned, MEM_fault, MEM_busy, MEM_kick_up}, 32'h0);
        check("rst_be", 32'(dmem_be), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        do_op(32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 0);
        do_op(32'h0000_0103, 32'h0, 32'h80FF_7F01, 1'b1, 1'b0, 2'b00, 1'b1, 2);
        check("signed_byte_const", MEM_result, 32'hFFFF_FF80);
        do_op(32'h0000_0103, 32'h0, 32'h80FF_7F01, 1'b1, 1'b0, 2'b00, 1'b0, 2);
        check("unsigned_byte_const", MEM_result, 32'h0000_0080);
        do_op(32'h0000_0022, 32'h0000_ABCD, 32'h0, 1'b0, 1'b1, 2'b01, 1'b0, 0);
        do_op(32'h0000_0041, 32'h0, 32'h1234_5678, 1'b1, 1'b0, 2'b10, 1'b0, 0);
        check("misaligned_const", 32'(MEM_misaligned), 32'h1);
        do_op(32'h0000_0200, 32'h0, 32'h1234_5678, 1'b1, 1'b0, 2'b10, 1'b0, 99);
        check("timeout_const", 32'(MEM_fault), 32'h1);
        do_op(32'h0000_0303, 32'h5A, 32'h0, 1'b1, 1'b1, 2'b11, 1'b0, 1);

        // Reset in the middle of an access must drop dmem_req without a clock edge.
        @(negedge clk);
        ALU_result = 32'h0000_0400; Controller_memread = 1'b1; Controller_memwrite = 1'b0;
        Controller_memsize = 2'b10; ALU_kick_up = 1'b1;
        @(negedge clk);
        ALU_kick_up = 1'b0;
        check("req_before_rst", 32'(dmem_req), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rst_async_req", 32'(dmem_req), 32'h0);
        check("rst_async_busy", 32'(MEM_busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        do_op(32'h0000_0400, 32'h0, 32'hCAFE_BABE, 1'b1, 1'b0, 2'b10, 1'b0, 1);

        for (int n = 0; n < 300; n++) begin
            int sel;
            sel = $urandom_range(0, 3);
            do_op($urandom, $urandom, $urandom, 1'(sel == 1 || sel == 3), 1'(sel >= 2),
                  2'($urandom), 1'($urandom), $urandom_range(0, 5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
